// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared single-port memory; master 1 wins contention.
// Define ARB_ROUND_ROBIN_EN to alternate winners under contention instead.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                m0_req_i,
   input  logic                m0_we_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_be_i,
   output logic                m0_gnt_o,
   output logic                m0_rvalid_o,
   output logic [DATA_W-1:0]   m0_rdata_o,
   input  logic                m1_req_i,
   input  logic                m1_we_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   input  logic [DATA_W/8-1:0] m1_be_i,
   output logic                m1_gnt_o,
   output logic                m1_rvalid_o,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   input  logic                mem_ready_i
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t r_state;
   logic   r_owner;
   logic   r_m0_rvalid;
   logic   r_m1_rvalid;
   logic   w_ready;
   logic   w_m1_wins;
   logic   w_gnt0;
   logic   w_gnt1;
   logic   w_gnt;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last <= 1'b0;
      end else if (w_gnt) begin
         r_last <= w_gnt1;
      end
   end

   assign w_m1_wins = ~r_last;
`else
   assign w_m1_wins = 1'b1;
`endif

   // Reset gates the grant too, so nothing reaches memory while held in reset.
   always_comb begin
      w_ready = mem_ready_i & rst_ni;
      w_gnt1  = w_ready & m1_req_i & (~m0_req_i | w_m1_wins);
      w_gnt0  = w_ready & m0_req_i & ~w_gnt1;
      w_gnt   = w_gnt0 | w_gnt1;
   end

   assign m0_gnt_o = w_gnt0;
   assign m1_gnt_o = w_gnt1;

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (w_gnt1) begin
         mem_req_o   = 1'b1;
         mem_we_o    = m1_we_i;
         mem_addr_o  = m1_addr_i;
         mem_wdata_o = m1_wdata_i;
         mem_be_o    = m1_be_i;
      end else if (w_gnt0) begin
         mem_req_o   = 1'b1;
         mem_we_o    = m0_we_i;
         mem_addr_o  = m0_addr_i;
         mem_wdata_o = m0_wdata_i;
         mem_be_o    = m0_be_i;
      end
   end

   // A return completes regardless of mem_ready_i: the memory already latched it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_owner     <= 1'b0;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
      end else if (w_gnt && !mem_we_o) begin
         r_state     <= RESP;
         r_owner     <= w_gnt1;
         r_m0_rvalid <= w_gnt0;
         r_m1_rvalid <= w_gnt1;
      end else begin
         r_state     <= IDLE;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
      end
   end

   assign m0_rvalid_o = r_m0_rvalid;
   assign m1_rvalid_o = r_m1_rvalid;
   assign m0_rdata_o  = r_m0_rvalid ? mem_rdata_i : '0;
   assign m1_rdata_o  = r_m1_rvalid ? mem_rdata_i : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter that shares the single-port external data/instruction memory between the instruction-fetch unit (master 0) and the load/store unit (master 1).
- Sits between the core and the memory. The memory reads with one cycle of registered latency, writes on the clock edge, and reports ready on mem_ready_i.
- Drives one request per cycle onto the memory port and returns read data to the master that issued the read.

Parameters:
- ADDR_W, 32, width of address buses.
- DATA_W, 32, width of data buses; byte-enable width is DATA_W/8.

Ports:
- clk_i  in  1  system clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- m0_req_i  in  1  master 0 request
- m0_we_i  in  1  master 0 write enable
- m0_addr_i  in  ADDR_W  master 0 byte address
- m0_wdata_i  in  DATA_W  master 0 write data
- m0_be_i  in  DATA_W/8  master 0 byte enables
- m0_gnt_o  out  1  master 0 request accepted this cycle
- m0_rvalid_o  out  1  master 0 read data valid
- m0_rdata_o  out  DATA_W  master 0 read data
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_be_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: identical to the master 0 set, for master 1
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_rdata_i  in  DATA_W  memory read data, valid one cycle after a read request
- mem_ready_i  in  1  memory can accept a request

Behaviour:
- Handshake: a master holds req/we/addr/wdata/be stable until it sees gnt. A request is transferred in a cycle where req && gnt, sampled at the rising edge.
- Grant is combinational within the cycle. If mem_ready_i=0, all gnt=0 and mem_req_o=0.
- Winner selection:
  - Only one master requesting: that master wins.
  - Both requesting: master 1 wins (fixed priority).
- mem_* outputs:
  - When a grant is given, mem_* mirror the winner's signals and mem_req_o=1.
  - With no grant, mem_req_o=0, mem_we_o=0, mem_be_o=0, and addr/wdata are don't-care (drive 0).
- FSM states:
  - IDLE: no read outstanding.
  - RESP: one read outstanding; an owner register (0/1) records the issuing master.
- FSM transitions:
  - From IDLE or RESP, a granted read moves to RESP and loads the owner register.
  - A granted write, or no grant, moves to IDLE.
  - A read and a write are never outstanding together.
- Read return:
  - In RESP, mN_rvalid_o=1 for owner N only, and mN_rdata_o=mem_rdata_i.
  - The non-owner's rvalid_o=0 and its rdata_o=0.
- Back-to-back: a new grant is permitted in the same cycle as a RESP return. Reads therefore sustain one per cycle with 1-cycle latency.
- Writes: complete at the granting edge; no rvalid is produced.
- Reset:
  - Asynchronous, immediately forces state IDLE and owner 0.
  - All gnt/rvalid outputs 0, mem_req_o 0.
  - A read outstanding at reset is dropped; no rvalid is ever produced for it.
- mem_ready_i low while in RESP: the read return still completes, because data is already latched by the memory. Only new grants are blocked.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant register, reset to 0, updates on every grant.
  - When both masters request, the master not granted last wins.
  - Contention therefore alternates 1,0,1,0 starting with master 1 after reset.
- Undefined: fixed priority, master 1 always wins contention; the register is not implemented.

Test Plan:
- Single read: m0 read addr 0x10 (memory word 0xDEADBEEF), mem_ready_i=1 -> m0_gnt_o=1 in cycle 0; m0_rvalid_o=1 and m0_rdata_o=0xDEADBEEF in cycle 1; m1_rvalid_o=0.
- Contention, fixed priority: m0 reads 0x0 and m1 writes 0x55AA55AA with be=4'b0011 to 0x4, both from cycle 0 -> cycle 0: m1_gnt_o=1, mem_we_o=1, mem_be_o=4'b0011. Cycle 1: m0_gnt_o=1. Cycle 2: m0_rvalid_o=1.
- Back-to-back reads: m1 reads 0x0, 0x4, 0x8 on consecutive cycles -> gnt every cycle; m1_rvalid_o high for cycles 1-3, with data in address order.
- Ready stall: mem_ready_i=0 for 3 cycles with m0_req_i=1 -> no gnt and mem_req_o=0; grant in the first cycle mem_ready_i=1.
- Reset mid-read: grant an m0 read, then assert rst_ni=0 before the next edge -> state IDLE and no m0_rvalid_o after reset release.
- ARB_ROUND_ROBIN_EN defined, both masters continuously reading -> grants alternate m1, m0, m1, m0; each rvalid is routed to the matching master.
